// File: rtl/mealy_hist_pkg.sv
// Shared types and helpers for the mealy_hist detector bank.
package mealy_hist_pkg;

  typedef enum logic [1:0] {
    MODE_GEN  = 2'b00,
    MODE_AND  = 2'b01,
    MODE_OR   = 2'b10,
    MODE_RISE = 2'b11
  } mode_t;

  // Widest counter the saturating helper handles; narrower counters are zero-extended in.
  localparam int SAT_W = 32;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                               input logic             inc,
                                               input logic [SAT_W-1:0] max);
    if (inc && (cnt != max)) return cnt + SAT_W'(1);
    return cnt;
  endfunction

endpackage

// File: rtl/mealy_hist_channel.sv
// One detector channel: history shift register of a, mode-selected qc, saturating hit
// counter and an optional output register.
module mealy_hist_channel
  import mealy_hist_pkg::*;
#(
  parameter int DEPTH   = 1,
  parameter int CNT_W   = 8,
  parameter int REG_OUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  mode_t            mode,
  input  logic             a,
  input  logic             b,
  output logic             q,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

  logic [DEPTH-1:0] hist;
  logic [DEPTH-1:0] hist_nxt;
  logic             all_h;
  logic             any_h;
  logic             qc;

  if (DEPTH == 1) begin : g_d1
    assign hist_nxt = a;
  end else begin : g_dn
    assign hist_nxt = {hist[DEPTH-2:0], a};
  end

  assign all_h = &hist;
  assign any_h = |hist;

  always_comb begin
    qc = 1'b0;
    unique case (mode)
      MODE_GEN:  qc = b ? (a | any_h) : (a & all_h);
      MODE_AND:  qc = a & all_h;
      MODE_OR:   qc = a | any_h;
      MODE_RISE: qc = a & ~hist[0];
      default:   qc = 1'b0;
    endcase
  end

  // history/counter stage: clr outranks en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist    <= '0;
      hit_cnt <= '0;
    end else if (clr) begin
      hist    <= '0;
      hit_cnt <= '0;
    end else if (en) begin
      hist    <= hist_nxt;
      hit_cnt <= CNT_W'(sat_inc(SAT_W'(hit_cnt), qc, CNT_MAX));
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic q_p1;
    // output stage: follows qc every edge, independent of en
    always_ff @(posedge clk or posedge reset) begin
      if (reset)    q_p1 <= 1'b0;
      else if (clr) q_p1 <= 1'b0;
      else          q_p1 <= qc;
    end
    assign q = q_p1;
  end else begin : g_comb
    assign q = qc;
  end

endmodule

// File: rtl/mealy_hist_array.sv
// Bank of N independent history-based Mealy detectors with packed hit counters.
module mealy_hist_array
  import mealy_hist_pkg::*;
#(
  parameter int N       = 4,
  parameter int DEPTH   = 1,
  parameter int CNT_W   = 8,
  parameter int REG_OUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       en,
  input  logic               clr,
  input  mode_t              mode,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  output logic [N-1:0]       q,
  output logic [N*CNT_W-1:0] hit_cnt
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    mealy_hist_channel #(
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W),
      .REG_OUT(REG_OUT)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .clr    (clr),
      .mode   (mode),
      .a      (a[i]),
      .b      (b[i]),
      .q      (q[i]),
      .hit_cnt(hit_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_mealy_hist_array.sv
// Randomised and directed bench for mealy_hist_array across three parameter sets.
module tb_mealy_hist_array;
  import mealy_hist_pkg::*;

  // Instance 0: N=4 DEPTH=3 CNT_W=2 comb; 1: N=1 DEPTH=1 CNT_W=8 comb; 2: N=2 DEPTH=2 CNT_W=3 registered
  localparam int NN  [3] = '{4, 1, 2};
  localparam int DEP [3] = '{3, 1, 2};
  localparam int CW  [3] = '{2, 8, 3};
  localparam int RO  [3] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  mode_t      mode = MODE_GEN;
  logic [3:0] en = '0, a = '0, b = '0;

  logic [3:0] q0;
  logic [7:0] hc0;
  logic [0:0] q1;
  logic [7:0] hc1;
  logic [1:0] q2;
  logic [5:0] hc2;

  int passed = 0;
  int total  = 0;

  // Reference state: past a values per instance/channel (index 0 newest), counts, registered q.
  bit mh [3][4][3];
  int mc [3][4];
  bit mq [3][4];

  always #5 clk = ~clk;

  mealy_hist_array #(.N(4), .DEPTH(3), .CNT_W(2), .REG_OUT(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode),
    .a(a), .b(b), .q(q0), .hit_cnt(hc0));

  mealy_hist_array #(.N(1), .DEPTH(1), .CNT_W(8), .REG_OUT(0)) dut1 (
    .clk(clk), .reset(reset), .en(en[0:0]), .clr(clr), .mode(mode),
    .a(a[0:0]), .b(b[0:0]), .q(q1), .hit_cnt(hc1));

  mealy_hist_array #(.N(2), .DEPTH(2), .CNT_W(3), .REG_OUT(1)) dut2 (
    .clk(clk), .reset(reset), .en(en[1:0]), .clr(clr), .mode(mode),
    .a(a[1:0]), .b(b[1:0]), .q(q2), .hit_cnt(hc2));

  function automatic bit model_qc(int d, int ch, bit av, bit bv, mode_t m);
    bit all1 = 1'b1;
    bit any1 = 1'b0;
    for (int k = 0; k < DEP[d]; k++) begin
      all1 = all1 & mh[d][ch][k];
      any1 = any1 | mh[d][ch][k];
    end
    case (m)
      MODE_GEN: return bv ? (av | any1) : (av & all1);
      MODE_AND: return av & all1;
      MODE_OR:  return av | any1;
      default:  return av & ~mh[d][ch][0];
    endcase
  endfunction

  function automatic logic [7:0] exp_q(int d);
    logic [7:0] v = '0;
    for (int ch = 0; ch < NN[d]; ch++)
      v[ch] = (RO[d] != 0) ? mq[d][ch] : model_qc(d, ch, a[ch], b[ch], mode);
    return v;
  endfunction

  function automatic logic [7:0] exp_hc(int d);
    logic [7:0] v = '0;
    for (int ch = 0; ch < NN[d]; ch++)
      v = v | (8'(mc[d][ch]) << (ch * CW[d]));
    return v;
  endfunction

  function automatic logic [7:0] act_q(int d);
    case (d)
      0: return {4'b0, q0};
      1: return {7'b0, q1};
      default: return {6'b0, q2};
    endcase
  endfunction

  function automatic logic [7:0] act_hc(int d);
    case (d)
      0: return hc0;
      1: return hc1;
      default: return {2'b0, hc2};
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int ch = 0; ch < 4; ch++) begin
        mc[d][ch] = 0;
        mq[d][ch] = 1'b0;
        for (int k = 0; k < 3; k++) mh[d][ch][k] = 1'b0;
      end
  endtask

  task automatic model_update();
    for (int d = 0; d < 3; d++)
      for (int ch = 0; ch < NN[d]; ch++) begin
        bit qv = model_qc(d, ch, a[ch], b[ch], mode);
        if (RO[d] != 0) mq[d][ch] = clr ? 1'b0 : qv;
        if (clr) begin
          mc[d][ch] = 0;
          for (int k = 0; k < 3; k++) mh[d][ch][k] = 1'b0;
        end else if (en[ch]) begin
          for (int k = 2; k > 0; k--) mh[d][ch][k] = mh[d][ch][k-1];
          mh[d][ch][0] = a[ch];
          mc[d][ch] = mc[d][ch] + int'(qv);
          if (mc[d][ch] > (1 << CW[d]) - 1) mc[d][ch] = (1 << CW[d]) - 1;
        end
      end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    model_reset();
    mode = MODE_GEN; a = 4'b0101; b = 4'b0011; en = 4'b1111;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (act_hc(d) !== 8'h00) $display("FAIL reset_hc%0d got %h want 00", d, act_hc(d));
      else passed++;
    end
    total++;
    if (q0 !== (a & b)) $display("FAIL reset_q0_gen got %b want %b", q0, a & b);
    else passed++;
    total++;
    if (q2 !== 2'b00) $display("FAIL reset_q2 got %b want 00", q2);
    else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    en = '0; a = '0; b = '0;
  endtask

  task automatic test_gen_original();
    bit [1:0] ab   [5] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b11};
    bit       want [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    mode = MODE_GEN; en = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      a[0] = ab[i][1]; b[0] = ab[i][0];
      #1;
      total++;
      if (q1[0] !== want[i]) $display("FAIL gen_orig step %0d got %b want %b", i, q1[0], want[i]);
      else passed++;
      total++;
      if (act_q(0) !== exp_q(0)) $display("FAIL gen_model_q0 step %0d got %h want %h", i, act_q(0), exp_q(0));
      else passed++;
      step();
    end
  endtask

  task automatic test_and_depth();
    bit av   [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    bit want [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    clr = 1'b1; step(); clr = 1'b0;
    mode = MODE_AND; en = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      a = {4{av[i]}};
      #1;
      total++;
      if (q0[0] !== want[i]) $display("FAIL and_depth3 step %0d got %b want %b", i, q0[0], want[i]);
      else passed++;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act_q(d) !== exp_q(d)) $display("FAIL and_model_q%0d step %0d got %h want %h", d, i, act_q(d), exp_q(d));
        else passed++;
      end
      step();
    end
  endtask

  task automatic test_saturate();
    int want [6] = '{1, 2, 3, 3, 3, 3};
    clr = 1'b1; step(); clr = 1'b0;
    mode = MODE_OR; en = 4'b1111; a = 4'b1111; b = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (int'(hc0[1:0]) != want[i]) $display("FAIL sat_cnt2 step %0d got %0d want %0d", i, hc0[1:0], want[i]);
      else passed++;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act_hc(d) !== exp_hc(d)) $display("FAIL sat_model_hc%0d step %0d got %h want %h", d, i, act_hc(d), exp_hc(d));
        else passed++;
      end
    end
  endtask

  task automatic test_enable_hold_clear();
    logic [7:0] held [3];
    for (int d = 0; d < 3; d++) held[d] = act_hc(d);
    en = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom); b = 4'($urandom); mode = mode_t'($urandom_range(0, 3));
      #1;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act_q(d) !== exp_q(d)) $display("FAIL hold_q%0d step %0d got %h want %h", d, i, act_q(d), exp_q(d));
        else passed++;
      end
      step();
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act_hc(d) !== held[d]) $display("FAIL hold_hc%0d step %0d got %h want %h", d, i, act_hc(d), held[d]);
        else passed++;
      end
    end
    clr = 1'b1; en = 4'b1111; a = 4'b1111; mode = MODE_OR;
    step();
    clr = 1'b0; en = 4'b0000; mode = MODE_AND;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (act_hc(d) !== 8'h00) $display("FAIL clr_hc%0d got %h want 00", d, act_hc(d));
      else passed++;
    end
    total++;
    if (q0 !== 4'b0000) $display("FAIL clr_hist_and got %b want 0000", q0);
    else passed++;
  endtask

  task automatic test_rise_registered();
    clr = 1'b1; step(); clr = 1'b0;
    mode = MODE_RISE; en = 4'b0011; a = 4'b0000;
    step();
    a = 4'b0001;
    #1;
    total++;
    if (q2[0] !== 1'b0) $display("FAIL rise_before_edge got %b want 0", q2[0]);
    else passed++;
    step();
    total++;
    if (q2[0] !== 1'b1) $display("FAIL rise_after_edge got %b want 1", q2[0]);
    else passed++;
    step();
    total++;
    if (q2[0] !== 1'b0) $display("FAIL rise_one_cycle got %b want 0", q2[0]);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      en = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
      mode = mode_t'($urandom_range(0, 3));
      clr = ($urandom_range(0, 15) == 0);
      #1;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (act_q(d) !== exp_q(d)) $display("FAIL rand_q%0d cyc %0d got %h want %h", d, i, act_q(d), exp_q(d));
        else passed++;
        total++;
        if (act_hc(d) !== exp_hc(d)) $display("FAIL rand_hc%0d cyc %0d got %h want %h", d, i, act_hc(d), exp_hc(d));
        else passed++;
      end
      step();
    end
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = MODE_OR; en = 4'b1111; a = 4'b1111; b = 4'b0000;
    step(); step();
    mode = MODE_RISE; a = 4'b0011;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (act_hc(d) !== 8'h00) $display("FAIL async_hc%0d got %h want 00", d, act_hc(d));
      else passed++;
    end
    total++;
    if (q2 !== 2'b00) $display("FAIL async_qreg got %b want 00", q2);
    else passed++;
    total++;
    if (q0 !== 4'b0011) $display("FAIL async_rise_hist0 got %b want 0011", q0);
    else passed++;
    mode = MODE_GEN; a = 4'b1111; b = 4'b0000;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (q0 !== 4'b0000 || q1 !== 1'b0) $display("FAIL post_reset_gen got %b/%b want 0000/0", q0, q1);
    else passed++;
    step();
    total++;
    if (q2 !== 2'b00) $display("FAIL post_reset_qreg got %b want 00", q2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_gen_original();
    test_and_depth();
    test_saturate();
    test_enable_hold_clear();
    test_rise_registered();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
